cmp_run_ctrl: RTL

- Parametrised hardware run controller for an N-node Cardinal CMP.
- Sequences core reset and measures program run time.
- Detects program completion: every enabled node fetches the terminating NOP (32'h00000000) in the same cycle.
- Drains the pipelines, then walks every node's data memory through a valid/ready dump port.
- Replaces fixed 4-node bench sequencing. Sits between a host/debug interface and the cardinal_cmp top, so runs can be driven on FPGA or in gate-level sim.

---
 rtl/cmp_run_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/cmp_run_ctrl.sv
// Run controller for an N-node Cardinal CMP: it sequences core reset, times the program run,
// detects completion on a NOP, drains the pipelines, then walks data memory out of a dump port.
module cmp_run_ctrl #(
  parameter int unsigned         NUM_NODES    = 4,
  parameter int unsigned         INST_W       = 32,
  parameter logic [NUM_NODES-1:0] NODE_MASK   = {NUM_NODES{1'b1}},
  parameter int unsigned         RESET_CYCLES = 5,
  parameter int unsigned         DRAIN_CYCLES = 30,
  parameter int unsigned         DUMP_DEPTH   = 128,
  parameter int unsigned         ADDR_W       = 8,
  parameter int unsigned         CYC_W        = 32,
  parameter int unsigned         TIMEOUT      = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NUM_NODES*INST_W-1:0] node_inst_in,
  input  logic                        dump_ready,
  output logic                        core_reset,
  output logic                        run_active,
  output logic [CYC_W-1:0]            cycle_count,
  output logic [CYC_W-1:0]            final_cycles,
  output logic                        dump_valid,
  output logic [ADDR_W-1:0]           dump_addr,
  output logic                        done,
  output logic                        timeout
);

  typedef enum logic [2:0] {
    StIdle,
    StRstHold,
    StRun,
    StDrain,
    StDump,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       phase_q, phase_d;
  logic              core_reset_q, core_reset_d;
  logic              run_active_q, run_active_d;
  logic [CYC_W-1:0]  cycle_q, cycle_d;
  logic [CYC_W-1:0]  final_q, final_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;

  logic [NUM_NODES-1:0] node_zero;
  logic                 all_hit;
  logic                 wd_hit;
  logic [CYC_W-1:0]     cycle_inc;

  // Node 0 occupies the most significant instruction slot.
  always_comb begin
    node_zero = '0;
    for (int i = 0; i < int'(NUM_NODES); i++) begin
      node_zero[i] = (node_inst_in[(int'(NUM_NODES) - 1 - i) * int'(INST_W) +: INST_W] == '0);
    end
  end

  assign all_hit   = &(node_zero | ~NODE_MASK);
  assign wd_hit    = (TIMEOUT != 0) && (cycle_q == CYC_W'(TIMEOUT - 1));
  assign cycle_inc = (cycle_q == '1) ? cycle_q : cycle_q + CYC_W'(1);

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    core_reset_d = core_reset_q;
    run_active_d = run_active_q;
    cycle_d      = cycle_q;
    final_d      = final_q;
    valid_d      = valid_q;
    addr_d       = addr_q;
    done_d       = done_q;
    timeout_d    = timeout_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          phase_d   = '0;
          cycle_d   = '0;
          addr_d    = '0;
          done_d    = 1'b0;
          timeout_d = 1'b0;
          if (RESET_CYCLES == 0) begin
            state_d      = StRun;
            core_reset_d = 1'b0;
            run_active_d = 1'b1;
          end else begin
            state_d      = StRstHold;
            core_reset_d = 1'b1;
          end
        end
      end

      StRstHold: begin
        if (phase_q == 32'(RESET_CYCLES - 1)) begin
          state_d      = StRun;
          phase_d      = '0;
          core_reset_d = 1'b0;
          run_active_d = 1'b1;
        end else begin
          phase_d = phase_q + 32'd1;
        end
      end

      StRun: begin
        cycle_d = cycle_inc;
        // Completion takes priority over a watchdog expiring in the same cycle.
        if (all_hit || wd_hit) begin
          final_d   = cycle_q;
          timeout_d = !all_hit;
          phase_d   = '0;
          if (DRAIN_CYCLES == 0) begin
            state_d      = StDump;
            run_active_d = 1'b0;
            valid_d      = 1'b1;
            addr_d       = '0;
          end else begin
            state_d = StDrain;
          end
        end
      end

      StDrain: begin
        cycle_d = cycle_inc;
        if (phase_q == 32'(DRAIN_CYCLES - 1)) begin
          state_d      = StDump;
          phase_d      = '0;
          run_active_d = 1'b0;
          valid_d      = 1'b1;
          addr_d       = '0;
        end else begin
          phase_d = phase_q + 32'd1;
        end
      end

      StDump: begin
        if (valid_q && dump_ready) begin
          if (addr_q == ADDR_W'(DUMP_DEPTH - 1)) begin
            state_d = StDone;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      phase_q      <= '0;
      core_reset_q <= 1'b1;
      run_active_q <= 1'b0;
      cycle_q      <= '0;
      final_q      <= '0;
      valid_q      <= 1'b0;
      addr_q       <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      core_reset_q <= core_reset_d;
      run_active_q <= run_active_d;
      cycle_q      <= cycle_d;
      final_q      <= final_d;
      valid_q      <= valid_d;
      addr_q       <= addr_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
    end
  end

  assign core_reset   = core_reset_q;
  assign run_active   = run_active_q;
  assign cycle_count  = cycle_q;
  assign final_cycles = final_q;
  assign dump_valid   = valid_q;
  assign dump_addr    = addr_q;
  assign done         = done_q;
  assign timeout      = timeout_q;

endmodule
